// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the convolution sequencing controller.
// The state encoding is fixed at 4 bits with IDLE=0 and ERROR=15 so that
// status logic and debug tooling can decode the state bus directly.
package conv_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ARM       = 4'd1,
    WAIT_DATA = 4'd2,
    FIND_SP   = 4'd3,
    FILL1     = 4'd4,
    FILL2     = 4'd5,
    RUN       = 4'd6,
    NEXT_PSUM = 4'd7,
    NEXT_IF   = 4'd8,
    UPDATE_SP = 4'd9,
    PSUM_RD   = 4'd10,
    PSUM_WR   = 4'd11,
    WAIT_WR   = 4'd12,
    DONE      = 4'd13,
    ERROR     = 4'd15
  } state_t;

  localparam int DEF_FILTER_ADDR_WIDTH = 8;
  localparam int DEF_NUM_LANES         = 4;
  localparam int DEF_WR_TIMEOUT        = 64;

  // Datapath conditions that stall the MAC pipeline.
  typedef struct packed {
    logic reading_empty;
    logic filter_cannot_read;
    logic sp_valid;
  } stall_bits_t;

  // The pipeline is frozen when input data, filter data or a start pointer is missing.
  function automatic logic calc_freeze(input stall_bits_t s);
    return s.reading_empty | s.filter_cannot_read | ~s.sp_valid;
  endfunction

endpackage

// File: rtl/wr_timeout_counter.sv
// Saturating cycle counter for the psum write-acknowledge wait.
// expired is asserted in the last permitted WAIT_WR cycle (count would reach
// WR_TIMEOUT on the next edge without an ack), so the FSM spends at most
// WR_TIMEOUT cycles waiting.
module wr_timeout_counter #(
  parameter int WR_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic ack,
  output logic expired
);

  localparam int CW = $clog2(WR_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WR_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(WR_TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count cycles spent waiting; clear outside the wait and on acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!en || ack) begin
      count <= '0;
    end else if (count != CNT_MAX) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && !ack && (count >= CNT_LAST);

endmodule

// File: rtl/conv_seq_controller.sv
// Sequencing FSM for the multi-lane convolution datapath.
// Optional feature macro: CONV_PSUM_ACCUM_EN compiles in the psum
// read-modify-write path (PSUM_RD -> PSUM_WR -> WAIT_WR with timeout).
// Without it, the end of a job goes straight to DONE and psum_ren/psum_wen are 0.
module conv_seq_controller
  import conv_ctrl_pkg::*;
#(
  parameter int FILTER_ADDR_WIDTH = DEF_FILTER_ADDR_WIDTH,
  parameter int NUM_LANES         = DEF_NUM_LANES,
  parameter int WR_TIMEOUT        = DEF_WR_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         if_empty,
  input  logic                         reading_empty,
  input  logic                         filter_cannot_read,
  input  logic                         sp_valid,
  input  logic [FILTER_ADDR_WIDTH-1:0] filter_count,
  input  logic                         f_co,
  input  logic                         psum_w_co,
  input  logic                         stride_ended,
  input  logic                         go_next_stride,
  input  logic                         go_next_filter,
  input  logic                         is_last_filter,
  input  logic                         ended,
  input  logic [NUM_LANES-1:0]         lane_mask,
  input  logic                         psum_valid,
  input  logic                         can_read_psum,
  input  logic                         wr_ack,
  input  logic                         error,
  output logic                         chip_en,
  output logic                         global_rst,
  output logic                         en_p_traverse,
  output logic                         ren,
  output logic                         ld_if,
  output logic                         i_en,
  output logic                         en_f_counter,
  output logic                         rst_f_counter,
  output logic                         next_stride,
  output logic                         next_filter,
  output logic                         rst_stride,
  output logic                         next_start,
  output logic                         make_empty,
  output logic                         psum_ren,
  output logic                         next_psum_raddr,
  output logic                         next_psum_waddr,
  output logic                         psum_wen,
  output logic [NUM_LANES-1:0]         mult_en,
  output logic [NUM_LANES-1:0]         ld_result,
  output logic                         busy,
  output logic                         done,
  output logic                         err_flag,
  output logic [3:0]                   dbg_state
);

  // Handshakes: strobes are single-cycle level requests valid in the cycle
  // they are high; the datapath acts on them at the next rising edge. Inputs
  // are sampled at that same edge; no extra register stages are inserted.

  state_t               state, state_next;
  logic [NUM_LANES-1:0] lane_q;
  logic                 freeze, run, wr_expired;

  assign freeze    = calc_freeze('{reading_empty: reading_empty,
                                   filter_cannot_read: filter_cannot_read,
                                   sp_valid: sp_valid});
  assign run       = !freeze && !f_co;
  assign dbg_state = state;

`ifdef CONV_PSUM_ACCUM_EN
  wr_timeout_counter #(.WR_TIMEOUT(WR_TIMEOUT)) u_wr_timeout (
    .clk     (clk),
    .reset   (reset),
    .en      (state == WAIT_WR),
    .ack     (wr_ack),
    .expired (wr_expired)
  );
`else
  logic unused_psum_inputs;
  assign wr_expired         = 1'b0;
  assign unused_psum_inputs = &{1'b0, psum_valid, can_read_psum, wr_ack, wr_expired,
                                (WR_TIMEOUT > 0)};
`endif

  // State register and lane mask latched when the job launches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      lane_q <= '0;
    end else begin
      state <= state_next;
      if (state == ARM && !start) lane_q <= lane_mask;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_next      = state;
    global_rst      = 1'b0;
    en_p_traverse   = 1'b0;
    ren             = 1'b0;
    ld_if           = 1'b0;
    i_en            = 1'b0;
    en_f_counter    = 1'b0;
    rst_f_counter   = 1'b0;
    next_stride     = 1'b0;
    next_filter     = 1'b0;
    rst_stride      = 1'b0;
    next_start      = 1'b0;
    make_empty      = 1'b0;
    psum_ren        = 1'b0;
    next_psum_raddr = 1'b0;
    next_psum_waddr = 1'b0;
    psum_wen        = 1'b0;
    mult_en         = '0;
    ld_result       = '0;
    done            = 1'b0;
    err_flag        = 1'b0;
    chip_en         = (state != IDLE);
    busy            = (state != IDLE) && (state != ERROR);

    case (state)
      IDLE: if (start) state_next = ARM;
      ARM: begin
        global_rst = 1'b1;
        if (!start) state_next = WAIT_DATA;
      end
      WAIT_DATA: if (!if_empty && filter_count != '0) state_next = FIND_SP;
      FIND_SP: begin
        en_p_traverse = !sp_valid;
        if (sp_valid) state_next = FILL1;
      end
      FILL1: if (!freeze) begin
        ren        = 1'b1;
        ld_if      = 1'b1;
        i_en       = 1'b1;
        state_next = FILL2;
      end
      FILL2: if (!freeze) begin
        ren        = 1'b1;
        ld_if      = 1'b1;
        i_en       = 1'b1;
        mult_en    = lane_q;
        state_next = RUN;
      end
      RUN: begin
        ren          = run;
        ld_if        = run;
        i_en         = run;
        en_f_counter = run;
        mult_en      = lane_q & {NUM_LANES{run}};
        ld_result    = lane_q & {NUM_LANES{run}};
        next_stride  = run && go_next_stride && !stride_ended && !ended;
        next_filter  = !freeze && go_next_filter;
        rst_stride   = !freeze && go_next_filter;
        if (is_last_filter && go_next_filter) begin
          state_next = NEXT_IF;
        end else if (ended) begin
`ifdef CONV_PSUM_ACCUM_EN
          state_next = PSUM_RD;
`else
          state_next = DONE;
`endif
        end else if (!freeze && f_co) begin
          state_next = NEXT_PSUM;
        end
      end
      NEXT_IF: begin
        make_empty = 1'b1;
        rst_stride = 1'b1;
        state_next = UPDATE_SP;
      end
      UPDATE_SP: begin
        next_start = 1'b1;
        state_next = RUN;
      end
      NEXT_PSUM: begin
        rst_f_counter   = 1'b1;
        next_psum_waddr = 1'b1;
        next_psum_raddr = 1'b1;
        state_next      = psum_w_co ? DONE : RUN;
      end
`ifdef CONV_PSUM_ACCUM_EN
      PSUM_RD: begin
        psum_ren = can_read_psum;
        if (psum_valid) state_next = PSUM_WR;
      end
      PSUM_WR: begin
        psum_wen   = 1'b1;
        state_next = WAIT_WR;
      end
      WAIT_WR: begin
        if (wr_ack) state_next = NEXT_PSUM;
        else if (wr_expired) state_next = ERROR;
      end
`endif
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERROR: begin
        err_flag = 1'b1;
        if (start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Abort and datapath faults pre-empt every other transition.
    if (state != IDLE && (abort || error)) state_next = ERROR;
  end

endmodule

// File: doc/conv_seq_controller.md
# conv_seq_controller

Parametrised sequencing FSM for the convolution datapath; successor to the single-lane main controller. Drives start-pointer search, three-stage pipeline fill/run, filter and stride advance, and partial-sum write-back for `NUM_LANES` parallel MAC lanes. Adds a per-lane enable mask, a timed write-acknowledge handshake, and recoverable error/abort back to IDLE. Sits between the top-level start/status logic and the IFMAP, filter, start-pointer and psum buffer datapath.

## Interface
- `FILTER_ADDR_WIDTH`, 8: width of `filter_count`.
- `NUM_LANES`, 4: parallel MAC lanes; ≥1.
- `WR_TIMEOUT`, 64: maximum cycles in WAIT_WR before error; ≥1.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; a job launches on its falling edge.
- `abort`  in  1  synchronous abort request.
- `if_empty`, `reading_empty`, `filter_cannot_read`, `sp_valid`  in  1 each  datapath status.
- `filter_count`  in  FILTER_ADDR_WIDTH  filter words loaded.
- `f_co`, `psum_w_co`, `stride_ended`, `go_next_stride`, `go_next_filter`, `is_last_filter`, `ended`  in  1 each  counter status.
- `lane_mask`  in  NUM_LANES  active lanes; sampled in ARM.
- `psum_valid`, `can_read_psum`, `wr_ack`, `error`  in  1 each  buffer handshakes and datapath fault.
- `chip_en`, `global_rst`, `en_p_traverse`, `ren`, `ld_if`, `i_en`, `en_f_counter`, `rst_f_counter`, `next_stride`, `next_filter`, `rst_stride`, `next_start`, `make_empty`, `psum_ren`, `next_psum_raddr`, `next_psum_waddr`, `psum_wen`  out  1 each  datapath strobes.
- `mult_en`, `ld_result`  out  NUM_LANES  per-lane strobes, ANDed with the latched mask.
- `busy`, `done`, `err_flag`  out  1 each  job status.

## Operation
- States: IDLE, ARM, WAIT_DATA, FIND_SP, FILL1, FILL2, RUN, NEXT_PSUM, NEXT_IF, UPDATE_SP, PSUM_RD, PSUM_WR, WAIT_WR, DONE, ERROR.
- IDLE → ARM on `start`=1. ARM holds while `start`=1 and drives `global_rst`. On `start`=0 it latches `lane_mask` and goes to WAIT_DATA.
- WAIT_DATA → FIND_SP when `!if_empty && filter_count!=0`.
- FIND_SP drives `en_p_traverse` while `!sp_valid` and moves to FILL1 on `sp_valid`.
- `freeze = reading_empty | filter_cannot_read | !sp_valid`. FILL1 and FILL2 hold while frozen.
  - FILL1 drives `ren`, `ld_if`, `i_en`.
  - FILL2 drives the FILL1 set plus `mult_en`.
- RUN:
  - `run = !freeze & !f_co` gates `ren`, `ld_if`, `i_en`, `mult_en`, `ld_result`, `en_f_counter`.
  - `next_stride = run & go_next_stride & !stride_ended & !ended`.
  - `next_filter = rst_stride = !freeze & go_next_filter`.
- RUN priority, highest first:
  1. `is_last_filter & go_next_filter` → NEXT_IF.
  2. `ended` → PSUM_RD (accumulate) or DONE.
  3. `!freeze & f_co` → NEXT_PSUM.
- NEXT_IF pulses `make_empty` and `rst_stride`, then UPDATE_SP. UPDATE_SP pulses `next_start`, then RUN.
- NEXT_PSUM pulses `rst_f_counter`, `next_psum_waddr`, `next_psum_raddr`. It then goes to DONE if `psum_w_co`, otherwise back to RUN.
- DONE pulses `done` for one cycle, then IDLE.
- `abort` or `error` in any non-IDLE state → ERROR, overriding every other transition.
- ERROR drives `err_flag`, holds all strobes 0, and leaves for IDLE only on `start`=1.
- `busy` = state ∉ {IDLE, ERROR}. `chip_en` = state ≠ IDLE.

## Timing
- Reset: state=IDLE, latched mask=0, timeout counter=0. Every output is 0 during and after reset.
- Strobes are combinational from the registered state and current inputs; there are no extra register stages.
- Pipeline latency: the first `ld_result` appears no earlier than 2 unfrozen cycles after FILL1 is entered.
- Write handshake:
  - PSUM_RD holds `psum_ren = can_read_psum` until `psum_valid`.
  - PSUM_WR pulses `psum_wen` for one cycle.
  - WAIT_WR waits for `wr_ack`. On ack it goes to NEXT_PSUM and the counter clears.
  - Counter width is `$clog2(WR_TIMEOUT+1)`. When the count reaches WR_TIMEOUT without `wr_ack`, the FSM goes to ERROR.
- `wr_ack` together with `error` in the same cycle: `error` wins.
- Reset asserted mid-job forces IDLE immediately. No `done` is emitted.
- `lane_mask`=0 is legal: the FSM sequences normally and all per-lane strobes stay 0.

## Configuration
- `CONV_PSUM_ACCUM_EN`, defined: the psum read-modify-write path is compiled in.
  - `ended` in RUN → PSUM_RD → PSUM_WR → WAIT_WR.
- `CONV_PSUM_ACCUM_EN`, undefined:
  - PSUM_RD, PSUM_WR, WAIT_WR and the timeout counter are removed.
  - `psum_ren` and `psum_wen` are tied to 0.
  - `ended` goes straight to DONE.

## Structure
- Package `conv_ctrl_pkg` holds:
  - the state enum typedef, 4-bit encoding, IDLE=0, ERROR=15;
  - default parameter constants;
  - the `freeze` bit-field helper function.
- One sub-module, `wr_timeout_counter`, contains the saturating WAIT_WR counter and its `expired` flag.

## Test plan
- Reset, then `start` 1→0 with `if_empty`=0, `filter_count`=3 and `sp_valid` rising after 2 cycles: `en_p_traverse` high for 2 cycles, FILL1 on the next cycle, first `ld_result` after 2 more cycles.
- `lane_mask`=4'b0101 in RUN: `mult_en`=`ld_result`=4'b0101 every unfrozen cycle.
- `reading_empty` held high for 5 cycles in FILL2: state unchanged and all strobes 0 for those 5 cycles, then resumes.
- `is_last_filter`=`go_next_filter`=1 in RUN: sequence NEXT_IF → UPDATE_SP → RUN, with `make_empty` and `next_start` each pulsing exactly once.
- Accumulate build, `wr_ack` withheld, WR_TIMEOUT=4: ERROR entered 4 cycles into WAIT_WR, `err_flag`=1, `start`=1 returns to IDLE.
- `abort` pulsed mid-RUN, then reset asserted mid-WAIT_DATA: ERROR on the next edge; after reset all outputs are 0 and `done` never pulses.
